fft_sram_sched: RTL and testbench

FFT_SRAM_SCHED -- requirements
Module: fft_sram_sched

---
 rtl/fft_sram_pkg.sv | 22 ++
 rtl/fft_sram_addr_gen.sv | 77 +++++++
 rtl/fft_sram_sched.sv | 188 ++++++++++++++++++
 tb/tb_fft_sram_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sram_pkg.sv
// fft_sram_pkg: bank codes, bank depths and FSM states shared by the FFT SRAM pass scheduler.
package fft_sram_pkg;

  localparam int unsigned LONG_DEPTH  = 128;
  localparam int unsigned SHORT_DEPTH = 32;

  typedef enum logic [1:0] {
    BANK_LONG = 2'd0,
    BANK_S1   = 2'd1,
    BANK_S2   = 2'd2,
    BANK_S3   = 2'd3
  } bank_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fft_sram_addr_gen.sv
// fft_sram_addr_gen: row adder and command legality check for the pass scheduler.
// FFT_SCHED_BITREV_EN adds bit-reversed write ordering and the power-of-two length rule.
module fft_sram_addr_gen
  import fft_sram_pkg::*;
#(
  parameter int AddrLWidth = 7,
  parameter int AddrSWidth = 5,
  parameter int LenWidth   = 8
) (
  input  logic [1:0]            i_src,
  input  logic [1:0]            i_dst,
  input  logic [LenWidth-1:0]   i_len,
  input  logic [AddrLWidth-1:0] i_src_base,
  input  logic [AddrLWidth-1:0] i_dst_base,
`ifdef FFT_SCHED_BITREV_EN
  input  logic                  i_bitrev,
  input  logic                  i_rev,
  input  logic [LenWidth-1:0]   i_pass_len,
`endif
  input  logic [AddrLWidth-1:0] i_base,
  input  logic [LenWidth-1:0]   i_count,
  output logic                  o_cmd_ok,
  output logic [AddrLWidth-1:0] o_row
);

  localparam int SumWidth = ((AddrLWidth > LenWidth) ? AddrLWidth : LenWidth) + 1;
  localparam int unsigned LongLim  =
    (LONG_DEPTH < (32'd1 << AddrLWidth)) ? LONG_DEPTH : (32'd1 << AddrLWidth);
  localparam int unsigned ShortLim =
    (SHORT_DEPTH < (32'd1 << AddrSWidth)) ? SHORT_DEPTH : (32'd1 << AddrSWidth);

  logic [SumWidth-1:0] w_src_end;
  logic [SumWidth-1:0] w_dst_end;
  logic [SumWidth-1:0] w_src_lim;
  logic [SumWidth-1:0] w_dst_lim;
  logic                w_mode_ok;
  logic [LenWidth-1:0] w_offset;

  // Sums are one bit wider than either operand so an over-long request cannot wrap past the check.
  assign w_src_end = SumWidth'(i_src_base) + SumWidth'(i_len);
  assign w_dst_end = SumWidth'(i_dst_base) + SumWidth'(i_len);
  assign w_src_lim = (i_src == BANK_LONG) ? SumWidth'(LongLim) : SumWidth'(ShortLim);
  assign w_dst_lim = (i_dst == BANK_LONG) ? SumWidth'(LongLim) : SumWidth'(ShortLim);

`ifdef FFT_SCHED_BITREV_EN
  localparam int ShW = $clog2(LenWidth + 1);

  logic [LenWidth-1:0] w_cnt_rev;
  logic [ShW-1:0]      w_log2_len;

  genvar gi;
  generate
    for (gi = 0; gi < LenWidth; gi++) begin : g_rev
      assign w_cnt_rev[gi] = i_count[LenWidth-1-gi];
    end
  endgenerate

  always_comb begin
    w_log2_len = '0;
    for (int i = 0; i < LenWidth; i++) begin
      if (i_pass_len[i]) w_log2_len = ShW'(i);
    end
  end

  // Full-width reversal shifted down leaves the reversal over exactly log2(len) bits.
  assign w_mode_ok = !i_bitrev || ((i_len & (i_len - LenWidth'(1))) == '0);
  assign w_offset  = i_rev ? (w_cnt_rev >> (ShW'(LenWidth) - w_log2_len)) : i_count;
`else
  assign w_mode_ok = 1'b1;
  assign w_offset  = i_count;
`endif

  assign o_cmd_ok = (i_src != i_dst) && (i_len != '0) &&
                    (w_src_end <= w_src_lim) && (w_dst_end <= w_dst_lim) && w_mode_ok;
  assign o_row    = i_base + AddrLWidth'(w_offset);

endmodule

// File: rtl/fft_sram_sched.sv
// fft_sram_sched: sequences one FFT pass, reading len rows from a source bank then writing len result rows.
// Define FFT_SCHED_BITREV_EN to add cmd_bitrev_i for bit-reversed write ordering.
module fft_sram_sched
  import fft_sram_pkg::*;
#(
  parameter int AddrLWidth = 7,
  parameter int AddrSWidth = 5,
  parameter int LenWidth   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_src_i,
  input  logic [1:0]                 cmd_dst_i,
  input  logic [LenWidth-1:0]        cmd_len_i,
  input  logic [AddrLWidth-1:0]      cmd_src_base_i,
  input  logic [AddrLWidth-1:0]      cmd_dst_base_i,
`ifdef FFT_SCHED_BITREV_EN
  input  logic                       cmd_bitrev_i,
`endif
  output logic                       rd_valid_o,
  output logic                       rd_last_o,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  output logic [3:0]                 sram_wen_o,
  output logic [1:0]                 sram_di_en_o,
  output logic [1:0]                 sram_do_en_o,
  output logic [3:0][AddrLWidth-1:0] sram_addr_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  state_e                r_state;
  logic [1:0]            r_src;
  logic [1:0]            r_dst;
  logic [LenWidth-1:0]   r_len;
  logic [AddrLWidth-1:0] r_src_base;
  logic [AddrLWidth-1:0] r_dst_base;
  logic [LenWidth-1:0]   r_cnt;
  logic                  r_rd_valid;
  logic                  r_rd_last;
  logic                  r_done;
  logic                  r_err;
`ifdef FFT_SCHED_BITREV_EN
  logic                  r_bitrev;
`endif

  logic                  w_accept;
  logic                  w_cmd_ok;
  logic                  w_cnt_last;
  logic [AddrLWidth-1:0] w_row;
  logic [AddrLWidth-1:0] w_base;
  logic                  w_row_valid;
  logic [1:0]            w_di_en;
  logic [1:0]            w_do_en;
  logic [3:0]            w_wen;

  assign cmd_ready_o = rst_ni && (r_state == ST_IDLE);
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  assign w_cnt_last  = (r_cnt == r_len - LenWidth'(1));

  fft_sram_addr_gen #(
    .AddrLWidth (AddrLWidth),
    .AddrSWidth (AddrSWidth),
    .LenWidth   (LenWidth)
  ) u_addr_gen (
    .i_src      (cmd_src_i),
    .i_dst      (cmd_dst_i),
    .i_len      (cmd_len_i),
    .i_src_base (cmd_src_base_i),
    .i_dst_base (cmd_dst_base_i),
`ifdef FFT_SCHED_BITREV_EN
    .i_bitrev   (cmd_bitrev_i),
    .i_rev      (r_bitrev && (r_state == ST_WRITE)),
    .i_pass_len (r_len),
`endif
    .i_base     (w_base),
    .i_count    (r_cnt),
    .o_cmd_ok   (w_cmd_ok),
    .o_row      (w_row)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef FFT_SCHED_BITREV_EN
      r_bitrev   <= 1'b0;
`endif
    end else begin
      // Read data returns one cycle after its address, so the valid/last flags trail READ by one.
      r_rd_valid <= (r_state == ST_READ);
      r_rd_last  <= (r_state == ST_READ) && w_cnt_last;
      r_done     <= (r_state == ST_DONE);
      r_err      <= w_accept && !w_cmd_ok;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_cmd_ok) begin
            r_src      <= cmd_src_i;
            r_dst      <= cmd_dst_i;
            r_len      <= cmd_len_i;
            r_src_base <= cmd_src_base_i;
            r_dst_base <= cmd_dst_base_i;
`ifdef FFT_SCHED_BITREV_EN
            r_bitrev   <= cmd_bitrev_i;
`endif
            r_cnt      <= '0;
            r_state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt <= r_cnt + LenWidth'(1);
          end
        end
        ST_DRAIN: r_state <= ST_WRITE;
        ST_WRITE: begin
          if (res_valid_i) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + LenWidth'(1);
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_di_en     = '0;
    w_do_en     = '0;
    w_base      = '0;
    w_row_valid = 1'b0;
    w_wen       = '0;
    case (r_state)
      ST_READ: begin
        w_di_en     = r_src;
        w_do_en     = r_src;
        w_base      = r_src_base;
        w_row_valid = 1'b1;
      end
      ST_DRAIN: w_do_en = r_src;
      ST_WRITE: begin
        w_di_en        = r_dst;
        w_base         = r_dst_base;
        w_row_valid    = 1'b1;
        w_wen[r_dst]   = res_valid_i;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign sram_addr_o[gi] = w_row_valid ? w_row : '0;
    end
  endgenerate

  assign sram_wen_o   = w_wen;
  assign sram_di_en_o = w_di_en;
  assign sram_do_en_o = w_do_en;
  assign res_ready_o  = (r_state == ST_WRITE);
  assign busy_o       = (r_state == ST_READ) || (r_state == ST_DRAIN) || (r_state == ST_WRITE);
  assign rd_valid_o   = r_rd_valid;
  assign rd_last_o    = r_rd_last;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_fft_sram_sched.sv
// tb_fft_sram_sched: table-driven and randomized passes checked cycle by cycle against a timeline model.
`timescale 1ns/1ps
module tb_fft_sram_sched;

  localparam int AW   = 7;
  localparam int LW   = 8;
  localparam int MAXC = 1200;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_src, cmd_dst;
  logic [LW-1:0]     cmd_len;
  logic [AW-1:0]     cmd_src_base, cmd_dst_base;
  logic              cmd_bitrev;
  logic              rd_valid, rd_last, res_valid, res_ready;
  logic [3:0]        sram_wen;
  logic [1:0]        sram_di_en, sram_do_en;
  logic [3:0][AW-1:0] sram_addr;
  logic              busy, done, err;

  always #5 clk = ~clk;

  fft_sram_sched dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_src_i      (cmd_src),
    .cmd_dst_i      (cmd_dst),
    .cmd_len_i      (cmd_len),
    .cmd_src_base_i (cmd_src_base),
    .cmd_dst_base_i (cmd_dst_base),
`ifdef FFT_SCHED_BITREV_EN
    .cmd_bitrev_i   (cmd_bitrev),
`endif
    .rd_valid_o     (rd_valid),
    .rd_last_o      (rd_last),
    .res_valid_i    (res_valid),
    .res_ready_o    (res_ready),
    .sram_wen_o     (sram_wen),
    .sram_di_en_o   (sram_di_en),
    .sram_do_en_o   (sram_do_en),
    .sram_addr_o    (sram_addr),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  typedef struct packed {
    logic          cmd_ready;
    logic          busy;
    logic          res_ready;
    logic          rd_valid;
    logic          rd_last;
    logic          done;
    logic          err;
    logic [3:0]    wen;
    logic [1:0]    di;
    logic [1:0]    dout;
    logic [4*AW-1:0] addr;
  } obs_t;

  typedef struct {
    logic [1:0] src;
    logic [1:0] dst;
    int         len;
    int         sbase;
    int         dbase;
    bit         brev;
    int         mode;
    bit         exp_ok;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rv [MAXC];
  vec_t tbl [$];

  task automatic check(input string name, input int cyc, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.cmd_ready = cmd_ready;
    o.busy      = busy;
    o.res_ready = res_ready;
    o.rd_valid  = rd_valid;
    o.rd_last   = rd_last;
    o.done      = done;
    o.err       = err;
    o.wen       = sram_wen;
    o.di        = sram_di_en;
    o.dout      = sram_do_en;
    o.addr      = sram_addr;
    return o;
  endfunction

  // Reference rules: distinct banks, nonzero length, rows fit the bank, power-of-two when bit-reversed.
  function automatic bit model_ok(input vec_t v);
    int sdep, ddep;
    bit ok;
    sdep = (v.src == 2'd0) ? 128 : 32;
    ddep = (v.dst == 2'd0) ? 128 : 32;
    ok = (v.src != v.dst) && (v.len > 0) && (v.sbase + v.len <= sdep) && (v.dbase + v.len <= ddep);
    if (v.brev && ((v.len & (v.len - 1)) != 0)) ok = 0;
    return ok;
  endfunction

  function automatic int log2i(input int n);
    int k = 0;
    while ((1 << (k + 1)) <= n) k++;
    return k;
  endfunction

  function automatic int rev_bits(input int w, input int k);
    int r = 0;
    for (int i = 0; i < k; i++) r = (r << 1) | ((w >> i) & 1);
    return r;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.cmd_ready = 1'b1;
    return o;
  endfunction

  task automatic run_cmd(input vec_t v);
    int wend, wcount, last, w, row, done_seen, wen_seen;
    logic [AW-1:0] row7;
    obs_t e, a;
    for (int c = 0; c < MAXC; c++) begin
      case (v.mode)
        0:       rv[c] = 1'b1;
        1:       rv[c] = (c % 2 == 0);
        default: rv[c] = (c > MAXC / 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      endcase
    end
    wend = -1;
    if (v.exp_ok) begin
      wcount = 0;
      for (int c = v.len + 2; c < MAXC && wend < 0; c++) begin
        if (rv[c]) begin
          wcount++;
          if (wcount == v.len) wend = c;
        end
      end
    end
    last = v.exp_ok ? wend + 3 : 2;
    w = 0;
    done_seen = -1;
    wen_seen = 0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cmd_src      = v.src;
        cmd_dst      = v.dst;
        cmd_len      = v.len[LW-1:0];
        cmd_src_base = v.sbase[AW-1:0];
        cmd_dst_base = v.dbase[AW-1:0];
        cmd_bitrev   = v.brev;
        cmd_valid    = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      res_valid = rv[c];
      #1;
      e = idle_obs();
      if (!v.exp_ok) begin
        e.err = (c == 1);
      end else begin
        e.cmd_ready = (c == 0) || (c >= wend + 2);
        e.busy      = (c >= 1) && (c <= wend);
        if (c >= 1 && c <= v.len) begin
          row7   = 7'(v.sbase + c - 1);
          e.di   = v.src;
          e.dout = v.src;
          e.addr = {4{row7}};
        end
        if (c == v.len + 1) e.dout = v.src;
        if (c >= v.len + 2 && c <= wend) begin
          row = v.dbase + (v.brev ? rev_bits(w, log2i(v.len)) : w);
          row7 = row[AW-1:0];
          e.res_ready = 1'b1;
          e.di        = v.dst;
          e.addr      = {4{row7}};
          if (rv[c]) e.wen = 4'b0001 << v.dst;
        end
        e.rd_valid = (c >= 2) && (c <= v.len + 1);
        e.rd_last  = (c == v.len + 1);
        e.done     = (c == wend + 2);
      end
      a = sample();
      check("vec", c, 64'(a), 64'(e));
      if (a.done && done_seen < 0) done_seen = c;
      if (a.wen != 4'b0) wen_seen++;
      if (v.exp_ok && c >= v.len + 2 && c <= wend && rv[c]) w++;
    end
    if (v.exp_ok) check("done_cyc", 0, 64'(done_seen), 64'(wend + 2));
    else check("rej_wen", 0, 64'(wen_seen), 64'(0));
  endtask

  task automatic reset_mid_write();
    obs_t a;
    @(negedge clk);
    cmd_src = 2'd0; cmd_dst = 2'd1; cmd_len = 8'd8;
    cmd_src_base = '0; cmd_dst_base = '0; cmd_bitrev = 1'b0;
    cmd_valid = 1'b1; res_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    a = sample();
    check("wen_pre_rst", 14, 64'(a.wen), 64'(4'b0010));
    @(negedge clk);
    #1;
    a = sample();
    check("rst_all_zero", 15, 64'(a), 64'(0));
    rst_n = 1'b1;
    for (int c = 16; c <= 18; c++) begin
      @(negedge clk);
      #1;
      a = sample();
      check("post_rst_idle", c, 64'(a), 64'(idle_obs()));
    end
  endtask

  initial begin
    obs_t a;
    vec_t v;
    rst_n = 1'b0; cmd_valid = 1'b0; res_valid = 1'b0; cmd_bitrev = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_src_base = '0; cmd_dst_base = '0;
    repeat (3) @(negedge clk);
    #1;
    a = sample();
    check("in_reset", 0, 64'(a), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    a = sample();
    check("after_reset", 0, 64'(a), 64'(idle_obs()));

    //               src    dst   len sb   db  brev mode ok
    tbl.push_back('{2'd0, 2'd2, 32,   0,   0, 1'b0, 0, 1'b1});
    tbl.push_back('{2'd3, 2'd1,  8,   0,  24, 1'b0, 1, 1'b1});
    tbl.push_back('{2'd1, 2'd1,  4,   0,   0, 1'b0, 0, 1'b0});
    tbl.push_back('{2'd0, 2'd1,  0,   0,   0, 1'b0, 0, 1'b0});
    tbl.push_back('{2'd1, 2'd2,  4,  30,   0, 1'b0, 0, 1'b0});
    tbl.push_back('{2'd0, 2'd3,  1, 127,  31, 1'b0, 2, 1'b1});
    tbl.push_back('{2'd2, 2'd0, 32,   0,  96, 1'b0, 2, 1'b1});
    tbl.push_back('{2'd0, 2'd1, 33,   0,   0, 1'b0, 0, 1'b0});
    tbl.push_back('{2'd0, 2'd2,  1,   0,  32, 1'b0, 0, 1'b0});
`ifdef FFT_SCHED_BITREV_EN
    tbl.push_back('{2'd1, 2'd0,  8,   0,   0, 1'b1, 0, 1'b1});
    tbl.push_back('{2'd1, 2'd0,  6,   0,   0, 1'b1, 0, 1'b0});
    tbl.push_back('{2'd0, 2'd3, 16,   4,  16, 1'b1, 2, 1'b1});
`endif
    for (int i = 0; i < tbl.size(); i++) run_cmd(tbl[i]);

    reset_mid_write();
    run_cmd('{2'd2, 2'd3, 4, 3, 5, 1'b0, 1, 1'b1});

    for (int i = 0; i < 25; i++) begin
      v.src   = 2'($urandom_range(0, 3));
      v.dst   = 2'($urandom_range(0, 3));
      v.len   = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 12));
      v.sbase = (v.src == 2'd0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 34));
      v.dbase = (v.dst == 2'd0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 34));
`ifdef FFT_SCHED_BITREV_EN
      v.brev  = $urandom_range(0, 1) != 0;
`else
      v.brev  = 1'b0;
`endif
      v.mode   = int'($urandom_range(0, 2));
      v.exp_ok = model_ok(v);
      run_cmd(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
